// File: rtl/ff25519_pkg.sv
// Shared GF(2^255-19) definitions: field width, modulus, default limb width,
// the arithmetic FSM state encoding and the limb operation select.
// Used by ff_sub_255, ff_add_255 and the scalar multiplier datapath.
package ff25519_pkg;

  localparam int F_W        = 255;
  localparam int LIMB_W_DEF = 51;

  // P = 2^255 - 19: all ones except the low five bits, 11111 - 10010 = 01101
  localparam logic [F_W-1:0] P = {{(F_W - 5){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } ff_state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } limb_op_t;

endpackage

// File: rtl/ff_limb_addsub.sv
// One limb of add or subtract with carry/borrow in and out.
// In OP_SUB mode cout is the borrow out (set when x < y + cin).
module ff_limb_addsub
  import ff25519_pkg::*;
#(
  parameter int W = LIMB_W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  limb_op_t     op,
  output logic [W-1:0] r,
  output logic         cout
);

  logic [W:0] t;

  // One extra bit holds carry (add) or borrow as a wrapped sign bit (subtract)
  always_comb begin
    if (op == OP_SUB) begin
      t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, cin};
    end else begin
      t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    end
  end

  assign r    = t[W-1:0];
  assign cout = t[W];

endmodule

// File: rtl/ff_sub_255.sv
// Limb-serial constant-time modular subtractor: result = (a - b) mod (2^255 - 19).
// SUB computes a - b mod 2^255 one limb per cycle (LSB first), the final borrow
// marks a negative difference. FIX then always adds (neg ? P : 0) limb by limb,
// so the cycle count never depends on operand values.
// Optional feature macro: FF_SUB_ERR_EN adds the in_err port and an input range
// check; with in_err set the delivered result is forced to zero.
//
// Handshake: start is accepted only in IDLE or DONE; an accepted start clears
// valid on the same edge. valid/result/in_err are written on the first edge
// spent in DONE and held there until the next accepted start.
module ff_sub_255
  import ff25519_pkg::*;
#(
  parameter int LIMB_W = LIMB_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [F_W-1:0] a,
  input  logic [F_W-1:0] b,
  output logic [F_W-1:0] result,
  output logic           valid,
  output logic           busy
`ifdef FF_SUB_ERR_EN
  ,
  output logic           in_err
`endif
);

  localparam int NLIMB = F_W / LIMB_W;
  localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

  ff_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [F_W-1:0]   a_sh;
  logic [F_W-1:0]   b_sh;
  logic [F_W-1:0]   d_sh;
  logic             cy;
  logic             neg;

  logic [8:0]        sh_amt;
  logic [LIMB_W-1:0] p_limb;
  logic [LIMB_W-1:0] op_x;
  logic [LIMB_W-1:0] op_y;
  limb_op_t          op_sel;
  logic [LIMB_W-1:0] limb_r;
  logic              limb_co;

`ifdef FF_SUB_ERR_EN
  logic err_q;
  logic range_bad;
  assign range_bad = (a >= P) || (b >= P);
`endif

  // Limb cnt of the modulus, selected from the constant by shifting
  assign sh_amt = 9'(cnt) * 9'(LIMB_W);
  assign p_limb = LIMB_W'(P >> sh_amt);

  // Operand select for the shared limb unit: a_i - b_i in SUB, d_i + masked P_i in FIX
  always_comb begin
    op_x   = a_sh[LIMB_W-1:0];
    op_y   = b_sh[LIMB_W-1:0];
    op_sel = OP_SUB;
    if (state == FIX) begin
      op_x   = d_sh[LIMB_W-1:0];
      op_y   = p_limb & {LIMB_W{neg}};
      op_sel = OP_ADD;
    end
  end

  ff_limb_addsub #(
    .W (LIMB_W)
  ) u_limb (
    .x    (op_x),
    .y    (op_y),
    .cin  (cy),
    .op   (op_sel),
    .r    (limb_r),
    .cout (limb_co)
  );

  // Control FSM, shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      cy     <= 1'b0;
      neg    <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
`ifdef FF_SUB_ERR_EN
      err_q  <= 1'b0;
      in_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            cy    <= 1'b0;
            cnt   <= '0;
            valid <= 1'b0;
            busy  <= 1'b1;
            state <= SUB;
`ifdef FF_SUB_ERR_EN
            err_q <= range_bad;
`endif
          end else if (state == DONE) begin
            valid <= 1'b1;
`ifdef FF_SUB_ERR_EN
            result <= err_q ? '0 : d_sh;
            in_err <= err_q;
`else
            result <= d_sh;
`endif
          end
        end
        SUB: begin
          d_sh <= F_W'({limb_r, d_sh} >> LIMB_W);
          a_sh <= a_sh >> LIMB_W;
          b_sh <= b_sh >> LIMB_W;
          if (cnt == LAST) begin
            neg   <= limb_co;
            cy    <= 1'b0;
            cnt   <= '0;
            state <= FIX;
          end else begin
            cy  <= limb_co;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          // Carry out of the top limb is dropped: the sum wraps mod 2^255
          d_sh <= F_W'({limb_r, d_sh} >> LIMB_W);
          if (cnt == LAST) begin
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cy  <= limb_co;
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
